// File: rtl/uart_frame_if.sv
// rtl/uart_frame_if.sv - byte-in / payload-out handshake bundle for uart_frame_sequencer
interface uart_frame_if;
   logic       rx_data_ready;
   logic [7:0] rx_data;
   logic       rx_endofpacket;
   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_last;
   logic       cmd_ready;

   modport master (
      output rx_data_ready, rx_data, rx_endofpacket, cmd_ready,
      input  cmd_valid, cmd_data, cmd_last
   );

   modport slave (
      input  rx_data_ready, rx_data, rx_endofpacket, cmd_ready,
      output cmd_valid, cmd_data, cmd_last
   );
endinterface

// File: rtl/uart_frame_sequencer.sv
// rtl/uart_frame_sequencer.sv - SYNC/LEN/payload/CHK framer with speculative payload FIFO
module uart_frame_sequencer #(
   parameter logic [7:0] SYNC_BYTE  = 8'hA5,
   parameter int         MAX_LEN    = 16,
   parameter int         FIFO_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          resetn,
   uart_frame_if.slave                   bus,
   output logic                          frame_ok,
   output logic                          frame_err,
   output logic [1:0]                    err_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LEN     = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;
   localparam logic [1:0] S_CHK     = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] cmt_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_ptr_next;
   logic [PW-1:0] used;
   logic [7:0]    remaining;
   logic [7:0]    sum;
   logic [7:0]    chk_sum;
   logic [15:0]   free_space;
   logic          truncate;
   logic          byte_in;
   logic          wr_en;
   logic          pop;
   logic          next_valid;
   logic [8:0]    mem [FIFO_DEPTH];

   // Line-idle outranks a byte arriving in the same cycle; that byte is dropped.
   assign truncate    = bus.rx_endofpacket && (state != S_IDLE);
   assign byte_in     = bus.rx_data_ready && !bus.rx_endofpacket;
   assign wr_en       = byte_in && (state == S_PAYLOAD);
   // Space is measured against the speculative write pointer so an in-flight
   // frame counts against the room available to the next one.
   assign used        = wr_ptr - rd_ptr;
   assign free_space  = 16'(FIFO_DEPTH) - 16'(used);
   assign chk_sum     = sum + bus.rx_data;
   assign pop         = bus.cmd_valid && bus.cmd_ready;
   assign rd_ptr_next = rd_ptr + PW'(pop);
   assign fifo_level  = cmt_ptr - rd_ptr;
   assign next_valid  = (cmt_ptr != rd_ptr_next);

   // Payload storage: {last, data}; written speculatively, only exposed once committed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= {remaining == 8'd1, bus.rx_data};
      end
   end

   // Frame FSM: parses the byte stream, owns wr_ptr/cmt_ptr and the status pulses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         cmt_ptr   <= '0;
         remaining <= '0;
         sum       <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (truncate) begin
            wr_ptr    <= cmt_ptr;
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_IDLE;
         end else if (byte_in) begin
            case (state)
               S_IDLE: begin
                  if (bus.rx_data == SYNC_BYTE) state <= S_LEN;
               end
               S_LEN: begin
                  if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd0;
                     state     <= S_IDLE;
                  end else if (free_space < {8'd0, bus.rx_data}) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd1;
                     state     <= S_IDLE;
                  end else begin
                     remaining <= bus.rx_data;
                     sum       <= bus.rx_data;
                     state     <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  wr_ptr    <= wr_ptr + PW'(1);
                  sum       <= chk_sum;
                  remaining <= remaining - 8'd1;
                  if (remaining == 8'd1) state <= S_CHK;
               end
               default: begin
                  if (chk_sum == 8'd0) begin
                     cmt_ptr  <= wr_ptr;
                     frame_ok <= 1'b1;
                  end else begin
                     wr_ptr    <= cmt_ptr;
                     frame_err <= 1'b1;
                     err_code  <= 2'd2;
                  end
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Show-ahead read port: registers the entry at the post-pop read pointer.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr       <= '0;
         bus.cmd_valid <= 1'b0;
         bus.cmd_data  <= 8'd0;
         bus.cmd_last  <= 1'b0;
      end else begin
         rd_ptr        <= rd_ptr_next;
         bus.cmd_valid <= next_valid;
         if (next_valid) begin
            {bus.cmd_last, bus.cmd_data} <= mem[rd_ptr_next[AW-1:0]];
         end else begin
            {bus.cmd_last, bus.cmd_data} <= 9'd0;
         end
      end
   end
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// tb/tb_uart_frame_sequencer.sv - directed self-checking bench for uart_frame_sequencer
module tb_uart_frame_sequencer;
   logic       clk = 1'b0;
   logic       resetn;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic [5:0] fifo_level;

   int chk_n  = 0;
   int pass_n = 0;
   int err_pulses = 0;

   logic [7:0] got_data [64];
   logic       got_last [64];
   int         got_n;
   bit         gap;

   uart_frame_if bus ();

   uart_frame_sequencer dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err) err_pulses++;

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data       = b;
      bus.rx_data_ready = 1'b1;
      @(negedge clk);
      bus.rx_data_ready = 1'b0;
   endtask

   task automatic send_good_frame();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
   endtask

   task automatic drain(input int n);
      int cyc;
      cyc = 0; got_n = 0; gap = 1'b0;
      bus.cmd_ready = 1'b1;
      while (got_n < n && cyc < 200) begin
         if (bus.cmd_valid) begin
            got_data[got_n] = bus.cmd_data;
            got_last[got_n] = bus.cmd_last;
            got_n++;
         end else if (got_n > 0) begin
            gap = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      bus.cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk_n++; if (bus.cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); else pass_n++;
      chk_n++; if (bus.cmd_data !== 8'h00) $display("FAIL reset_cmd_data: got %h want 00", bus.cmd_data); else pass_n++;
      chk_n++; if (bus.cmd_last !== 1'b0) $display("FAIL reset_cmd_last: got %b want 0", bus.cmd_last); else pass_n++;
      chk_n++; if (frame_ok !== 1'b0) $display("FAIL reset_frame_ok: got %b want 0", frame_ok); else pass_n++;
      chk_n++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_n++;
      chk_n++; if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d want 0", err_code); else pass_n++;
      chk_n++; if (fifo_level !== 6'd0) $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); else pass_n++;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame();
      send_good_frame();
      chk_n++; if (frame_ok !== 1'b1) $display("FAIL good_frame_ok: got %b want 1", frame_ok); else pass_n++;
      chk_n++; if (frame_err !== 1'b0) $display("FAIL good_frame_err: got %b want 0", frame_err); else pass_n++;
      chk_n++; if (bus.cmd_valid !== 1'b0) $display("FAIL good_valid_early: got %b want 0", bus.cmd_valid); else pass_n++;
      chk_n++; if (fifo_level !== 6'd3) $display("FAIL good_level3: got %0d want 3", fifo_level); else pass_n++;
      @(negedge clk);
      chk_n++; if (frame_ok !== 1'b0) $display("FAIL good_ok_pulse_width: got %b want 0", frame_ok); else pass_n++;
      chk_n++; if (bus.cmd_valid !== 1'b1) $display("FAIL good_valid_rise: got %b want 1", bus.cmd_valid); else pass_n++;
      drain(3);
      chk_n++; if (got_n !== 3) $display("FAIL good_count: got %0d want 3", got_n); else pass_n++;
      chk_n++; if ({got_data[0], got_data[1], got_data[2]} !== 24'h112233) $display("FAIL good_data: got %h%h%h want 112233", got_data[0], got_data[1], got_data[2]); else pass_n++;
      chk_n++; if ({got_last[0], got_last[1], got_last[2]} !== 3'b001) $display("FAIL good_last: got %b%b%b want 001", got_last[0], got_last[1], got_last[2]); else pass_n++;
      chk_n++; if (fifo_level !== 6'd0) $display("FAIL good_level0: got %0d want 0", fifo_level); else pass_n++;
      chk_n++; if (bus.cmd_valid !== 1'b0) $display("FAIL good_valid_fall: got %b want 0", bus.cmd_valid); else pass_n++;
   endtask

   task automatic test_bad_chk();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
      chk_n++; if (frame_err !== 1'b1) $display("FAIL badchk_err: got %b want 1", frame_err); else pass_n++;
      chk_n++; if (err_code !== 2'd2) $display("FAIL badchk_code: got %0d want 2", err_code); else pass_n++;
      chk_n++; if (frame_ok !== 1'b0) $display("FAIL badchk_ok: got %b want 0", frame_ok); else pass_n++;
      @(negedge clk);
      chk_n++; if (bus.cmd_valid !== 1'b0) $display("FAIL badchk_valid: got %b want 0", bus.cmd_valid); else pass_n++;
      chk_n++; if (err_code !== 2'd2) $display("FAIL badchk_code_held: got %0d want 2", err_code); else pass_n++;
      send_good_frame();
      drain(3);
      chk_n++; if (got_n !== 3 || {got_data[0], got_data[1], got_data[2]} !== 24'h112233) $display("FAIL badchk_next_frame: got %0d bytes %h%h%h want 3 bytes 112233", got_n, got_data[0], got_data[1], got_data[2]); else pass_n++;
   endtask

   task automatic test_truncation();
      send_byte(8'hA5);
      @(negedge clk);
      bus.rx_data = 8'h03; bus.rx_data_ready = 1'b1; bus.rx_endofpacket = 1'b1;
      @(negedge clk);
      bus.rx_data_ready = 1'b0; bus.rx_endofpacket = 1'b0;
      chk_n++; if (frame_err !== 1'b1 || err_code !== 2'd3) $display("FAIL trunc_simul: got err=%b code=%0d want err=1 code=3", frame_err, err_code); else pass_n++;
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
      @(negedge clk);
      bus.rx_endofpacket = 1'b1;
      @(negedge clk);
      bus.rx_endofpacket = 1'b0;
      chk_n++; if (frame_err !== 1'b1 || err_code !== 2'd3) $display("FAIL trunc_eop: got err=%b code=%0d want err=1 code=3", frame_err, err_code); else pass_n++;
      chk_n++; if (dut.wr_ptr !== dut.cmt_ptr) $display("FAIL trunc_rewind: got wr=%0d want %0d", dut.wr_ptr, dut.cmt_ptr); else pass_n++;
      @(negedge clk);
      bus.rx_endofpacket = 1'b1;
      @(negedge clk);
      bus.rx_endofpacket = 1'b0;
      chk_n++; if (frame_err !== 1'b0) $display("FAIL trunc_idle_eop: got %b want 0", frame_err); else pass_n++;
      send_good_frame();
      chk_n++; if (fifo_level !== 6'd3) $display("FAIL trunc_next_level: got %0d want 3", fifo_level); else pass_n++;
      drain(3);
      chk_n++; if (got_n !== 3 || {got_data[0], got_data[1], got_data[2]} !== 24'h112233) $display("FAIL trunc_next_frame: got %0d bytes %h%h%h want 3 bytes 112233", got_n, got_data[0], got_data[1], got_data[2]); else pass_n++;
   endtask

   task automatic test_len_limits();
      send_byte(8'hA5); send_byte(8'h00);
      chk_n++; if (frame_err !== 1'b1 || err_code !== 2'd0) $display("FAIL len_zero: got err=%b code=%0d want err=1 code=0", frame_err, err_code); else pass_n++;
      send_byte(8'hA5); send_byte(8'h11);
      chk_n++; if (frame_err !== 1'b1 || err_code !== 2'd0) $display("FAIL len_17: got err=%b code=%0d want err=1 code=0", frame_err, err_code); else pass_n++;
      send_byte(8'hA5); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'(i + 1));
      send_byte(8'h68);
      chk_n++; if (frame_ok !== 1'b1) $display("FAIL len_16_ok: got %b want 1", frame_ok); else pass_n++;
      drain(16);
      chk_n++; if (got_n !== 16) $display("FAIL len_16_count: got %0d want 16", got_n); else pass_n++;
      for (int i = 0; i < 16; i++) begin
         chk_n++;
         if (got_data[i] !== 8'(i + 1) || got_last[i] !== (i == 15)) $display("FAIL len_16_byte%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], 8'(i + 1), (i == 15));
         else pass_n++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] held;
      bus.cmd_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'(i + 1));
      send_byte(8'h68);
      send_byte(8'hA5); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'(8'h21 + i));
      send_byte(8'h68);
      chk_n++; if (fifo_level !== 6'd32) $display("FAIL bp_level32: got %0d want 32", fifo_level); else pass_n++;
      send_byte(8'hA5); send_byte(8'h01);
      chk_n++; if (frame_err !== 1'b1 || err_code !== 2'd1) $display("FAIL bp_nospace: got err=%b code=%0d want err=1 code=1", frame_err, err_code); else pass_n++;
      held = bus.cmd_data;
      repeat (3) @(negedge clk);
      chk_n++; if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== 8'h01 || held !== 8'h01) $display("FAIL bp_stable: got v=%b d=%h first=%h want v=1 d=01", bus.cmd_valid, bus.cmd_data, held); else pass_n++;
      drain(32);
      chk_n++; if (got_n !== 32) $display("FAIL bp_count: got %0d want 32", got_n); else pass_n++;
      chk_n++; if (gap !== 1'b0) $display("FAIL bp_rate: got gap=%b want 0", gap); else pass_n++;
      for (int i = 0; i < 32; i++) begin
         chk_n++;
         if (got_data[i] !== ((i < 16) ? 8'(i + 1) : 8'(8'h11 + i)) || got_last[i] !== (i == 15 || i == 31))
            $display("FAIL bp_byte%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], (i < 16) ? 8'(i + 1) : 8'(8'h11 + i), (i == 15 || i == 31));
         else pass_n++;
      end
      chk_n++; if (fifo_level !== 6'd0) $display("FAIL bp_level0: got %0d want 0", fifo_level); else pass_n++;
   endtask

   task automatic test_noise_reset();
      int errs_before;
      errs_before = err_pulses;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      send_good_frame();
      chk_n++; if (frame_ok !== 1'b1) $display("FAIL noise_ok: got %b want 1", frame_ok); else pass_n++;
      chk_n++; if (err_pulses !== errs_before) $display("FAIL noise_no_err: got %0d want %0d", err_pulses, errs_before); else pass_n++;
      send_byte(8'hA5); send_byte(8'h02);
      send_byte(8'h04);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      @(negedge clk);
      chk_n++; if (fifo_level !== 6'd3 || bus.cmd_valid !== 1'b1) $display("FAIL noise_prereset: got lvl=%0d v=%b want lvl=3 v=1", fifo_level, bus.cmd_valid); else pass_n++;
      resetn = 1'b0;
      @(negedge clk);
      chk_n++; if (bus.cmd_valid !== 1'b0 || bus.cmd_data !== 8'h00 || bus.cmd_last !== 1'b0) $display("FAIL rst_mid_cmd: got v=%b d=%h l=%b want 0/00/0", bus.cmd_valid, bus.cmd_data, bus.cmd_last); else pass_n++;
      chk_n++; if (frame_ok !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'd0) $display("FAIL rst_mid_status: got ok=%b err=%b code=%0d want 0/0/0", frame_ok, frame_err, err_code); else pass_n++;
      chk_n++; if (fifo_level !== 6'd0) $display("FAIL rst_mid_level: got %0d want 0", fifo_level); else pass_n++;
      resetn = 1'b1;
      send_good_frame();
      drain(3);
      chk_n++; if (got_n !== 3 || {got_data[0], got_data[1], got_data[2]} !== 24'h112233) $display("FAIL rst_next_frame: got %0d bytes %h%h%h want 3 bytes 112233", got_n, got_data[0], got_data[1], got_data[2]); else pass_n++;
   endtask

   initial begin
      resetn = 1'b0;
      bus.rx_data_ready = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_endofpacket = 1'b0;
      bus.cmd_ready = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_truncation();
      test_len_limits();
      test_back_to_back();
      test_noise_reset();
      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end
endmodule
